// File: rtl/dcmac_stats_pkg.sv
// Shared definitions for the DCMAC RX statistics accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: APB address field positions, APB read FSM state enum,
//           largest supported channel and counter counts.
package dcmac_stats_pkg;

  // APB address layout: [21:16] channel, [13:8] counter index, [2] half select
  localparam int CH_LSB   = 16;
  localparam int CH_W     = 6;
  localparam int IDX_LSB  = 8;
  localparam int IDX_W    = 6;
  localparam int HALF_BIT = 2;

  localparam int MAX_N_CH  = 64;
  localparam int MAX_N_CNT = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } apb_st_e;

endpackage

// File: rtl/dcmac_rx_stats_accum_if.sv
// APB3 bus bundle between software master and the stats accumulator.
// Latency: n/a (wires only).
// Backpressure: slave stretches transfers through pready.
// Ports: psel/penable/pwrite/paddr/pwdata from master; prdata/pready/pslverr from slave.
interface dcmac_rx_stats_accum_if;

  logic        APB_M_psel;
  logic        APB_M_penable;
  logic        APB_M_pwrite;
  logic [31:0] APB_M_paddr;
  logic [31:0] APB_M_pwdata;
  logic [31:0] APB_M_prdata;
  logic        APB_M_pready;
  logic        APB_M_pslverr;

  modport master (
    output APB_M_psel, APB_M_penable, APB_M_pwrite, APB_M_paddr, APB_M_pwdata,
    input  APB_M_prdata, APB_M_pready, APB_M_pslverr
  );

  modport slave (
    input  APB_M_psel, APB_M_penable, APB_M_pwrite, APB_M_paddr, APB_M_pwdata,
    output APB_M_prdata, APB_M_pready, APB_M_pslverr
  );

endinterface

// File: rtl/dcmac_stats_apb_rd.sv
// APB3 read/write front end: FSM, address capture, channel/index range check.
// Latency: reads complete in the 2nd access cycle (one wait state); writes in the 1st.
// Backpressure: pready low in the first read access cycle; writes never stall.
// Ports: clk/rst_n; apb (slave modport); req_ch/req_idx/req_half/req_vld out to
//        the storage; rd_dat/rd_vld back from the storage.
module dcmac_stats_apb_rd
  import dcmac_stats_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int N_CNT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcmac_rx_stats_accum_if.slave apb,
  output logic [CH_W-1:0]       req_ch,
  output logic [IDX_W-1:0]      req_idx,
  output logic                  req_half,
  output logic                  req_vld,
  input  logic [31:0]           rd_dat,
  input  logic                  rd_vld
);

  apb_st_e          state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             half_q, half_d;
  logic             err_q, err_d;
  logic [31:0]      prdata_q, prdata_d;

  logic setup;
  logic in_range;
  logic unused_apb;

  assign setup    = apb.APB_M_psel & ~apb.APB_M_penable;
  assign in_range = ({1'b0, ch_q} < 7'(N_CH)) && ({1'b0, idx_q} < 7'(N_CNT));

  // Data and address bits outside the decoded fields carry no meaning.
  assign unused_apb = ^{apb.APB_M_pwdata, apb.APB_M_paddr};

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    idx_d    = idx_q;
    half_d   = half_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (apb.APB_M_pwrite) begin
            // Registers are read-only: complete at once with an error.
            state_d  = RD_DONE;
            err_d    = 1'b1;
            prdata_d = '0;
          end else begin
            state_d = RD_WAIT;
            ch_d    = apb.APB_M_paddr[CH_LSB +: CH_W];
            idx_d   = apb.APB_M_paddr[IDX_LSB +: IDX_W];
            half_d  = apb.APB_M_paddr[HALF_BIT];
          end
        end
      end
      RD_WAIT: begin
        state_d = RD_DONE;
        if (rd_vld) begin
          prdata_d = rd_dat;
          err_d    = 1'b0;
        end else begin
          prdata_d = '0;
          err_d    = 1'b1;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      idx_q    <= '0;
      half_q   <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      idx_q    <= idx_d;
      half_q   <= half_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  assign req_ch   = ch_q;
  assign req_idx  = idx_q;
  assign req_half = half_q;
  assign req_vld  = (state_q == RD_WAIT) && in_range;

  // Response outputs are forced low everywhere except the completion cycle.
  assign apb.APB_M_pready  = (state_q == RD_DONE);
  assign apb.APB_M_pslverr = (state_q == RD_DONE) & err_q;
  assign apb.APB_M_prdata  = (state_q == RD_DONE) ? prdata_q : 32'd0;

endmodule

// File: rtl/dcmac_rx_stats_accum.sv
// Per-channel RX statistics accumulator: live counters, tick snapshots, APB3 readout.
// Latency: increments visible in live one cycle after valid; snapshot/clear on the tick edge.
// Backpressure: none on the stats input (accepted every cycle); APB reads use one wait state.
// Ports: apb3_clk/apb3_rstn; i_tdm_stats_valid/id/inc increment vector; ts_rst/ts_rst_id
//        soft clear; i_pm_tick per-channel snapshot; apb (slave modport) software access.
// Build option: DCMAC_STATS_SATURATE_EN clamps live counters at all-ones instead of wrapping.
module dcmac_rx_stats_accum
  import dcmac_stats_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int N_CNT = 16,
  parameter int CNT_W = 48,
  parameter int INC_W = 8
) (
  input  logic                   apb3_clk,
  input  logic                   apb3_rstn,
  input  logic                   i_tdm_stats_valid,
  input  logic [5:0]             i_tdm_stats_id,
  input  logic [N_CNT*INC_W-1:0] i_tdm_stats_inc,
  input  logic                   ts_rst,
  input  logic [5:0]             ts_rst_id,
  input  logic [N_CH-1:0]        i_pm_tick,
  dcmac_rx_stats_accum_if.slave  apb
);

  localparam int CH_IW  = (N_CH  > 1) ? $clog2(N_CH)  : 1;
  localparam int IDX_IW = (N_CNT > 1) ? $clog2(N_CNT) : 1;

  logic [CNT_W-1:0] live_q [N_CH][N_CNT];
  logic [CNT_W-1:0] live_d [N_CH][N_CNT];
  logic [CNT_W-1:0] snap_q [N_CH][N_CNT];
  logic [CNT_W-1:0] snap_d [N_CH][N_CNT];
  logic [CNT_W-1:0] upd;

  logic [CH_W-1:0]   req_ch;
  logic [IDX_W-1:0]  req_idx;
  logic              req_half;
  logic              req_vld;
  logic [31:0]       rd_dat;
  logic [63:0]       rd_w;
  logic [CH_IW-1:0]  ch_sel;
  logic [IDX_IW-1:0] idx_sel;
  logic              unused_req;

  function automatic logic [CNT_W-1:0] acc_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
`ifdef DCMAC_STATS_SATURATE_EN
    acc_add = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
`else
    acc_add = s[CNT_W-1:0];
`endif
  endfunction

  always_comb begin
    live_d = live_q;
    snap_d = snap_q;
    upd    = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < N_CNT; k++) begin
        if (ts_rst && (ts_rst_id == 6'(c))) begin
          // Soft clear beats any same-cycle increment or tick.
          live_d[c][k] = '0;
          snap_d[c][k] = '0;
        end else begin
          upd = (i_tdm_stats_valid && (i_tdm_stats_id == 6'(c)))
              ? acc_add(live_q[c][k], i_tdm_stats_inc[k*INC_W +: INC_W])
              : live_q[c][k];
          // The snapshot takes the post-increment value so no event is lost at the tick.
          if (i_pm_tick[c]) begin
            snap_d[c][k] = upd;
            live_d[c][k] = '0;
          end else begin
            live_d[c][k] = upd;
          end
        end
      end
    end
  end

  always_ff @(posedge apb3_clk or negedge apb3_rstn) begin
    if (!apb3_rstn) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < N_CNT; k++) begin
          live_q[c][k] <= '0;
          snap_q[c][k] <= '0;
        end
      end
    end else begin
      live_q <= live_d;
      snap_q <= snap_d;
    end
  end

  // Indices are truncated to the array width; req_vld guarantees they are in range.
  assign ch_sel     = req_ch[CH_IW-1:0];
  assign idx_sel    = req_idx[IDX_IW-1:0];
  assign unused_req = ^{req_ch, req_idx};

  always_comb begin
    rd_w   = '0;
    rd_dat = '0;
    if (req_vld) begin
      rd_w   = 64'(snap_q[ch_sel][idx_sel]);
      rd_dat = req_half ? rd_w[63:32] : rd_w[31:0];
    end
  end

  dcmac_stats_apb_rd #(
    .N_CH  (N_CH),
    .N_CNT (N_CNT)
  ) u_apb_rd (
    .clk      (apb3_clk),
    .rst_n    (apb3_rstn),
    .apb      (apb),
    .req_ch   (req_ch),
    .req_idx  (req_idx),
    .req_half (req_half),
    .req_vld  (req_vld),
    .rd_dat   (rd_dat),
    .rd_vld   (req_vld)
  );

endmodule

// File: tb/tb_dcmac_rx_stats_accum.sv
// Self-checking bench for dcmac_rx_stats_accum: directed cases plus random traffic
// compared against a per-channel array model, all results read back over APB.
module tb_dcmac_rx_stats_accum;

  localparam int N_CH  = 8;
  localparam int N_CNT = 8;
  localparam int CNT_W = 33;
  localparam int INC_W = 32;
  localparam int IW    = N_CNT * INC_W;
  localparam longint unsigned MASK = (64'd1 << CNT_W) - 64'd1;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            vld = 1'b0;
  logic [5:0]      id = '0;
  logic [IW-1:0]   inc = '0;
  logic            tsr = 1'b0;
  logic [5:0]      tsr_id = '0;
  logic [N_CH-1:0] tick = '0;

  always #5 clk = ~clk;

  dcmac_rx_stats_accum_if apb_if();

  dcmac_rx_stats_accum #(
    .N_CH  (N_CH),
    .N_CNT (N_CNT),
    .CNT_W (CNT_W),
    .INC_W (INC_W)
  ) dut (
    .apb3_clk          (clk),
    .apb3_rstn         (rstn),
    .i_tdm_stats_valid (vld),
    .i_tdm_stats_id    (id),
    .i_tdm_stats_inc   (inc),
    .ts_rst            (tsr),
    .ts_rst_id         (tsr_id),
    .i_pm_tick         (tick),
    .apb               (apb_if)
  );

  longint unsigned live_m [N_CH][N_CNT];
  longint unsigned snap_m [N_CH][N_CNT];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned m_add(input longint unsigned a, input longint unsigned b);
    longint unsigned s;
    s = a + b;
`ifdef DCMAC_STATS_SATURATE_EN
    return (s > MASK) ? MASK : s;
`else
    return s & MASK;
`endif
  endfunction

  function automatic logic [IW-1:0] mk_inc(input int k, input longint unsigned val);
    logic [IW-1:0] r;
    r = '0;
    r[k*INC_W +: INC_W] = INC_W'(val);
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < N_CNT; k++) begin
        live_m[c][k] = 0;
        snap_m[c][k] = 0;
      end
  endtask

  // One stats cycle: drive, clock, then apply the same event to the model.
  task automatic step(input logic v, input int i, input logic [IW-1:0] in,
                      input logic [N_CH-1:0] t, input logic r, input int rid);
    longint unsigned nv;
    @(negedge clk);
    vld = v; id = 6'(i); inc = in; tick = t; tsr = r; tsr_id = 6'(rid);
    @(posedge clk);
    for (int c = 0; c < N_CH; c++) begin
      if (r && rid == c) begin
        for (int k = 0; k < N_CNT; k++) begin
          live_m[c][k] = 0;
          snap_m[c][k] = 0;
        end
      end else begin
        for (int k = 0; k < N_CNT; k++) begin
          nv = (v && i == c) ? m_add(live_m[c][k], longint'(in[k*INC_W +: INC_W]))
                             : live_m[c][k];
          if (t[c]) begin
            snap_m[c][k] = nv;
            live_m[c][k] = 0;
          end else begin
            live_m[c][k] = nv;
          end
        end
      end
    end
    #1;
    vld = 1'b0; inc = '0; tick = '0; tsr = 1'b0;
  endtask

  function automatic logic [31:0] mk_addr(input int ch, input int idx, input int half);
    logic [31:0] a;
    a = '0;
    a[21:16] = 6'(ch);
    a[13:8]  = 6'(idx);
    a[2]     = half[0];
    return a;
  endfunction

  task automatic apb_rd(input int ch, input int idx, input int half,
                        output logic [31:0] d, output logic e);
    @(negedge clk);
    apb_if.APB_M_psel = 1'b1; apb_if.APB_M_penable = 1'b0;
    apb_if.APB_M_pwrite = 1'b0; apb_if.APB_M_paddr = mk_addr(ch, idx, half);
    @(negedge clk);
    apb_if.APB_M_penable = 1'b1;
    chk("rd_access1_pready", 64'(apb_if.APB_M_pready), 64'd0);
    @(negedge clk);
    chk("rd_access2_pready", 64'(apb_if.APB_M_pready), 64'd1);
    d = apb_if.APB_M_prdata;
    e = apb_if.APB_M_pslverr;
    apb_if.APB_M_psel = 1'b0; apb_if.APB_M_penable = 1'b0;
    @(negedge clk);
    chk("rd_after_pready", 64'(apb_if.APB_M_pready), 64'd0);
  endtask

  task automatic rd_chk(input string tag, input int ch, input int idx, input int half,
                        input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic        e;
    apb_rd(ch, idx, half, d, e);
    chk($sformatf("%s_data", tag), 64'(d), 64'(exp_d));
    chk($sformatf("%s_slverr", tag), 64'(e), 64'(exp_e));
  endtask

  task automatic apb_wr(input int ch, input int idx);
    @(negedge clk);
    apb_if.APB_M_psel = 1'b1; apb_if.APB_M_penable = 1'b0;
    apb_if.APB_M_pwrite = 1'b1; apb_if.APB_M_paddr = mk_addr(ch, idx, 0);
    apb_if.APB_M_pwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    apb_if.APB_M_penable = 1'b1;
    chk("wr_access1_pready", 64'(apb_if.APB_M_pready), 64'd1);
    chk("wr_access1_pslverr", 64'(apb_if.APB_M_pslverr), 64'd1);
    chk("wr_access1_prdata", 64'(apb_if.APB_M_prdata), 64'd0);
    apb_if.APB_M_psel = 1'b0; apb_if.APB_M_penable = 1'b0; apb_if.APB_M_pwrite = 1'b0;
    @(negedge clk);
    chk("wr_after_pready", 64'(apb_if.APB_M_pready), 64'd0);
  endtask

  task automatic rd_all(input string tag);
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < N_CNT; k++) begin
        rd_chk($sformatf("%s_c%0d_k%0d_lo", tag, c, k), c, k, 0,
               32'(snap_m[c][k] & 64'hFFFF_FFFF), 1'b0);
        rd_chk($sformatf("%s_c%0d_k%0d_hi", tag, c, k), c, k, 1,
               32'(snap_m[c][k] >> 32), 1'b0);
      end
  endtask

  initial begin
    logic [IW-1:0]   rin;
    logic [N_CH-1:0] rt;
    logic [31:0]     exp_lo, exp_hi;

    apb_if.APB_M_psel = 1'b0; apb_if.APB_M_penable = 1'b0; apb_if.APB_M_pwrite = 1'b0;
    apb_if.APB_M_paddr = '0; apb_if.APB_M_pwdata = '0;
    model_clear();

    // Reset state
    #1;
    chk("reset_prdata", 64'(apb_if.APB_M_prdata), 64'd0);
    chk("reset_pready", 64'(apb_if.APB_M_pready), 64'd0);
    chk("reset_pslverr", 64'(apb_if.APB_M_pslverr), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    rd_chk("reset_read_c0_k0", 0, 0, 0, 32'd0, 1'b0);

    // Three increments to ch2 counter 5, tick, read 60; second tick reads 0
    step(1, 2, mk_inc(5, 10), '0, 0, 0);
    step(1, 2, mk_inc(5, 20), '0, 0, 0);
    step(1, 2, mk_inc(5, 30), '0, 0, 0);
    step(0, 0, '0, 8'b0000_0100, 0, 0);
    rd_chk("acc_c2_k5_lo", 2, 5, 0, 32'd60, 1'b0);
    rd_chk("acc_c2_k5_hi", 2, 5, 1, 32'd0, 1'b0);
    step(0, 0, '0, 8'b0000_0100, 0, 0);
    rd_chk("acc_c2_k5_retick", 2, 5, 0, 32'd0, 1'b0);

    // Tick coinciding with an increment on the same channel
    step(1, 1, mk_inc(0, 5), '0, 0, 0);
    step(1, 1, mk_inc(0, 7), 8'b0000_0010, 0, 0);
    rd_chk("tick_inc_c1", 1, 0, 0, 32'd12, 1'b0);
    step(0, 0, '0, 8'b0000_0010, 0, 0);
    rd_chk("tick_inc_c1_live0", 1, 0, 0, 32'd0, 1'b0);

    // Soft clear on ch3 beats same-cycle increment and tick; ch4 unaffected
    step(1, 4, mk_inc(0, 9), '0, 0, 0);
    step(1, 3, mk_inc(0, 11), 8'b0000_1000, 0, 0);
    step(1, 3, mk_inc(0, 6), '0, 0, 0);
    step(1, 3, mk_inc(0, 4), 8'b0001_1000, 1, 3);
    rd_chk("tsrst_c3_snap", 3, 0, 0, 32'd0, 1'b0);
    rd_chk("tsrst_c4_snap", 4, 0, 0, 32'd9, 1'b0);
    step(0, 0, '0, 8'b0000_1000, 0, 0);
    rd_chk("tsrst_c3_live", 3, 0, 0, 32'd0, 1'b0);

    // Out-of-range vector and soft clear are ignored
    step(1, 9, mk_inc(0, 100), '0, 1, 12);
    step(0, 0, '0, 8'b0001_0000, 0, 0);
    rd_chk("oor_id_c4", 4, 0, 0, 32'd0, 1'b0);
    step(1, 4, mk_inc(0, 9), 8'b0001_0000, 0, 0);

    // Top of range: 2^CNT_W-3 plus 5
    step(1, 6, mk_inc(1, 64'hFFFF_FFFF), '0, 0, 0);
    step(1, 6, mk_inc(1, 64'hFFFF_FFFE), '0, 0, 0);
    step(1, 6, mk_inc(1, 5), '0, 0, 0);
    step(0, 0, '0, 8'b0100_0000, 0, 0);
`ifdef DCMAC_STATS_SATURATE_EN
    exp_lo = 32'hFFFF_FFFF; exp_hi = 32'd1;
`else
    exp_lo = 32'd2; exp_hi = 32'd0;
`endif
    rd_chk("top_c6_k1_lo", 6, 1, 0, exp_lo, 1'b0);
    rd_chk("top_c6_k1_hi", 6, 1, 1, exp_hi, 1'b0);

    // Range errors and writes
    rd_chk("err_ch", N_CH, 0, 0, 32'd0, 1'b1);
    rd_chk("err_idx", 0, N_CNT, 0, 32'd0, 1'b1);
    apb_wr(4, 0);
    rd_chk("after_wr_c4", 4, 0, 0, 32'd9, 1'b0);

    // Reset while pready is high
    @(negedge clk);
    apb_if.APB_M_psel = 1'b1; apb_if.APB_M_penable = 1'b0;
    apb_if.APB_M_pwrite = 1'b0; apb_if.APB_M_paddr = mk_addr(4, 0, 0);
    @(negedge clk);
    apb_if.APB_M_penable = 1'b1;
    @(negedge clk);
    chk("midrst_pre_pready", 64'(apb_if.APB_M_pready), 64'd1);
    chk("midrst_pre_prdata", 64'(apb_if.APB_M_prdata), 64'd9);
    rstn = 1'b0;
    #1;
    chk("midrst_pready", 64'(apb_if.APB_M_pready), 64'd0);
    chk("midrst_prdata", 64'(apb_if.APB_M_prdata), 64'd0);
    chk("midrst_pslverr", 64'(apb_if.APB_M_pslverr), 64'd0);
    apb_if.APB_M_psel = 1'b0; apb_if.APB_M_penable = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rd_chk("postrst_c4", 4, 0, 0, 32'd0, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rin = '0;
      for (int k = 0; k < N_CNT; k++)
        rin[k*INC_W +: INC_W] = ($urandom_range(0, 3) == 0) ? INC_W'($urandom)
                                                            : INC_W'($urandom_range(0, 1000));
      rt = '0;
      for (int c = 0; c < N_CH; c++)
        rt[c] = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9), rin, rt,
           $urandom_range(0, 15) == 0, $urandom_range(0, 9));
    end
    rd_all("rand_snap");
    step(0, 0, '0, '1, 0, 0);
    rd_all("rand_live");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
